// File: rtl/wb_bypass_queue_pkg.sv
// Shared types and constants for the writeback bypass queue.
package wb_bypass_queue_pkg;

  localparam int unsigned BYTE_TAG_W      = 16;
  localparam int unsigned BYTES_PER_ENTRY = 8;
  localparam int unsigned DATA_W          = 64;
  localparam int unsigned PTC_W           = BYTES_PER_ENTRY * BYTE_TAG_W;

  // Tag value for a byte nobody is producing; operands never carry it.
  localparam logic [BYTE_TAG_W-1:0] PTC_NULL = 16'hFFFF;

  // One resident writeback result: data plus its per-byte tags.
  typedef struct packed {
    logic [PTC_W-1:0]  ptc;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;

  localparam wbq_entry_t EMPTY_ENTRY = '{ptc: {BYTES_PER_ENTRY{PTC_NULL}}, data: '0};

  // Per-slot update selected by the queue control.
  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_SHIFT = 2'd1,
    SLOT_LOAD  = 2'd2,
    SLOT_CLEAR = 2'd3
  } slot_op_e;

  // Extract byte b's tag from a packed tag vector.
  function automatic logic [BYTE_TAG_W-1:0] tag_of(input logic [PTC_W-1:0] ptc,
                                                   input int unsigned      b);
    return ptc[b*BYTE_TAG_W +: BYTE_TAG_W];
  endfunction

endpackage

// File: rtl/wbq_slot.sv
// One queue slot: entry register with load / shift-in / clear and per-byte tag kill.
module wbq_slot
  import wb_bypass_queue_pkg::*;
(
  input  logic                       clk,
  input  logic                       clr,
  input  slot_op_e                   op,
  input  wbq_entry_t                 load_entry,
  input  wbq_entry_t                 shift_entry,
  input  logic [BYTES_PER_ENTRY-1:0] kill,
  output wbq_entry_t                 q,
  output wbq_entry_t                 q_killed_c
);

  wbq_entry_t d;

  // Current contents with this cycle's killed byte tags replaced by NULL; data is kept.
  always_comb begin
    q_killed_c = q;
    for (int unsigned b = 0; b < BYTES_PER_ENTRY; b++) begin
      if (kill[b]) begin
        q_killed_c.ptc[b*BYTE_TAG_W +: BYTE_TAG_W] = PTC_NULL;
      end
    end
  end

  // Next-contents select; shift_entry already carries the neighbour's kills.
  always_comb begin
    d = q_killed_c;
    case (op)
      SLOT_SHIFT: d = shift_entry;
      SLOT_LOAD:  d = load_entry;
      SLOT_CLEAR: d = EMPTY_ENTRY;
      default:    d = q_killed_c;
    endcase
  end

  // Entry register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= EMPTY_ENTRY;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/wb_bypass_queue.sv
// Writeback bypass queue: shifting queue of uncommitted results exposed as bypass prospects.
module wb_bypass_queue
  import wb_bypass_queue_pkg::*;
#(
  parameter  int unsigned NUM_PROSPECTS = 4,
  localparam int unsigned CNT_W         = $clog2(NUM_PROSPECTS) + 1
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic                              flush,
  input  logic                              enq_valid,
  output logic                              enq_ready,
  input  logic [DATA_W-1:0]                 enq_data,
  input  logic [PTC_W-1:0]                  enq_ptc,
  output logic                              deq_valid,
  output logic [DATA_W-1:0]                 deq_data,
  output logic [PTC_W-1:0]                  deq_ptc,
  input  logic                              deq_ack,
  output logic [NUM_PROSPECTS*DATA_W-1:0]   prospective_data,
  output logic [NUM_PROSPECTS*PTC_W-1:0]    prospective_ptc,
  output logic [CNT_W-1:0]                  count
);

  logic                                           enq_fire;
  logic                                           deq_fire;
  logic [CNT_W-1:0]                               count_next;
  logic [CNT_W-1:0]                               write_idx;
  wbq_entry_t                                     enq_entry;
  wbq_entry_t                                     slot_q     [NUM_PROSPECTS];
  wbq_entry_t                                     slot_kq    [NUM_PROSPECTS];
  wbq_entry_t                                     shift_in   [NUM_PROSPECTS];
  slot_op_e                                       slot_op    [NUM_PROSPECTS];
  logic [NUM_PROSPECTS-1:0][BYTES_PER_ENTRY-1:0]  kill;

  assign enq_ready = (count < CNT_W'(NUM_PROSPECTS));
  assign deq_valid = (count != '0);
  assign enq_fire  = enq_valid & enq_ready & ~flush;
  assign deq_fire  = deq_ack & deq_valid & ~flush;
  assign enq_entry = '{ptc: enq_ptc, data: enq_data};

  // After a dequeue the entries shift down, so the new entry lands one slot lower.
  assign write_idx = deq_fire ? (count - CNT_W'(1)) : count;

  // Occupancy update; flush empties the queue regardless of handshakes.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(enq_fire) - CNT_W'(deq_fire);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // Kill any resident byte whose tag is claimed by a non-NULL byte of the accepted entry.
  always_comb begin
    kill = '0;
    if (enq_fire) begin
      for (int unsigned k = 0; k < NUM_PROSPECTS; k++) begin
        for (int unsigned b = 0; b < BYTES_PER_ENTRY; b++) begin
          for (int unsigned j = 0; j < BYTES_PER_ENTRY; j++) begin
            if ((tag_of(enq_ptc, j) != PTC_NULL) &&
                (tag_of(enq_ptc, j) == tag_of(slot_q[k].ptc, b))) begin
              kill[k][b] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Per-slot operation: flush clears, enqueue loads its target, dequeue shifts the rest down.
  always_comb begin
    for (int unsigned k = 0; k < NUM_PROSPECTS; k++) begin
      slot_op[k] = SLOT_HOLD;
      if (flush) begin
        slot_op[k] = SLOT_CLEAR;
      end else if (enq_fire && (CNT_W'(k) == write_idx)) begin
        slot_op[k] = SLOT_LOAD;
      end else if (deq_fire) begin
        slot_op[k] = (k == NUM_PROSPECTS - 1) ? SLOT_CLEAR : SLOT_SHIFT;
      end
    end
  end

  for (genvar k = 0; k < NUM_PROSPECTS; k++) begin : g_slot
    // Neighbour feed for the down-shift; the top slot refills with the empty pattern.
    if (k == NUM_PROSPECTS - 1) begin : g_top
      assign shift_in[k] = EMPTY_ENTRY;
    end else begin : g_mid
      assign shift_in[k] = slot_kq[k+1];
    end

    wbq_slot u_slot (
      .clk         (clk),
      .clr         (clr),
      .op          (slot_op[k]),
      .load_entry  (enq_entry),
      .shift_entry (shift_in[k]),
      .kill        (kill[k]),
      .q           (slot_q[k]),
      .q_killed_c  (slot_kq[k])
    );

    assign prospective_data[k*DATA_W +: DATA_W] = slot_q[k].data;
    assign prospective_ptc[k*PTC_W +: PTC_W]    = slot_q[k].ptc;
  end

  assign deq_data = slot_q[0].data;
  assign deq_ptc  = slot_q[0].ptc;

endmodule

// File: tb/tb_wb_bypass_queue.sv
// Self-checking bench for wb_bypass_queue: queue-based reference model plus directed literal checks.
module tb_wb_bypass_queue;

  localparam int N = 4;

  logic           clk;
  logic           clr;
  logic           flush;
  logic           enq_valid;
  logic           enq_ready;
  logic [63:0]    enq_data;
  logic [127:0]   enq_ptc;
  logic           deq_valid;
  logic [63:0]    deq_data;
  logic [127:0]   deq_ptc;
  logic           deq_ack;
  logic [N*64-1:0]  prospective_data;
  logic [N*128-1:0] prospective_ptc;
  logic [2:0]     count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0]  d;
    logic [127:0] t;
  } ment_t;

  ment_t mq[$];

  wb_bypass_queue #(.NUM_PROSPECTS(N)) dut (
    .clk              (clk),
    .clr              (clr),
    .flush            (flush),
    .enq_valid        (enq_valid),
    .enq_ready        (enq_ready),
    .enq_data         (enq_data),
    .enq_ptc          (enq_ptc),
    .deq_valid        (deq_valid),
    .deq_data         (deq_data),
    .deq_ptc          (deq_ptc),
    .deq_ack          (deq_ack),
    .prospective_data (prospective_data),
    .prospective_ptc  (prospective_ptc),
    .count            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] tg(input logic [127:0] p, input int b);
    return p[b*16 +: 16];
  endfunction

  function automatic logic [127:0] mk_ptc(input logic [15:0] base);
    logic [127:0] p;
    for (int b = 0; b < 8; b++) p[b*16 +: 16] = base + 16'(b);
    return p;
  endfunction

  // Random tags from a small pool so kills are frequent; unique within one entry.
  function automatic logic [127:0] rand_ptc();
    logic [127:0] p;
    logic [31:0]  used;
    int           t;
    used = '0;
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 7) == 0) begin
        p[b*16 +: 16] = 16'hFFFF;
      end else begin
        t = $urandom_range(0, 23);
        while (used[t]) t = $urandom_range(0, 23);
        used[t] = 1'b1;
        p[b*16 +: 16] = 16'(t);
      end
    end
    return p;
  endfunction

  // Reference update for one rising edge from the queue contents and current inputs.
  task automatic model_step();
    ment_t e;
    bit    ef;
    bit    df;
    int    sz;
    sz = mq.size();
    if (flush) begin
      mq.delete();
      return;
    end
    ef = enq_valid && (sz < N);
    df = deq_ack && (sz > 0);
    if (ef) begin
      for (int i = 0; i < sz; i++) begin
        e = mq[i];
        for (int b = 0; b < 8; b++)
          for (int j = 0; j < 8; j++)
            if (tg(enq_ptc, j) != 16'hFFFF && tg(e.t, b) == tg(enq_ptc, j))
              e.t[b*16 +: 16] = 16'hFFFF;
        mq[i] = e;
      end
    end
    if (df) void'(mq.pop_front());
    if (ef) begin
      e.d = enq_data;
      e.t = enq_ptc;
      mq.push_back(e);
    end
  endtask

  task automatic check_model();
    logic [N*64-1:0]  exp_pd;
    logic [N*128-1:0] exp_pp;
    int sz;
    sz = mq.size();
    for (int k = 0; k < N; k++) begin
      exp_pd[k*64 +: 64]   = (k < sz) ? mq[k].d : 64'h0;
      exp_pp[k*128 +: 128] = (k < sz) ? mq[k].t : {8{16'hFFFF}};
    end
    check("m_count", 512'(count), 512'(sz));
    check("m_enq_ready", 512'(enq_ready), 512'(sz < N));
    check("m_deq_valid", 512'(deq_valid), 512'(sz != 0));
    check("m_deq_data", 512'(deq_data), 512'(exp_pd[63:0]));
    check("m_deq_ptc", 512'(deq_ptc), 512'(exp_pp[127:0]));
    check("m_pdata", 512'(prospective_data), 512'(exp_pd));
    check("m_pptc", 512'(prospective_ptc), 512'(exp_pp));
  endtask

  task automatic drive(input bit ev, input logic [63:0] d, input logic [127:0] p,
                       input bit ack, input bit fl);
    enq_valid = ev;
    enq_data  = d;
    enq_ptc   = p;
    deq_ack   = ack;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  localparam logic [63:0] D1 = 64'h1122334455667788;
  localparam logic [63:0] D2 = 64'hA2A2A2A2_00000002;
  localparam logic [63:0] D3 = 64'hA3A3A3A3_00000003;
  localparam logic [63:0] D4 = 64'hA4A4A4A4_00000004;
  localparam logic [63:0] D5 = 64'h55555555_00000005;
  localparam logic [63:0] DA = 64'hAAAA000011112222;
  localparam logic [63:0] DB = 64'hBBBB000033334444;
  localparam logic [63:0] DC = 64'hCCCC000055556666;

  initial begin
    logic [127:0] pa;
    logic [127:0] pb;
    clr = 1'b0;
    drive(0, '0, '0, 0, 0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    // Reset idle state, literal.
    check("rst_count", 512'(count), 512'(0));
    check("rst_enq_ready", 512'(enq_ready), 512'(1));
    check("rst_deq_valid", 512'(deq_valid), 512'(0));
    check("rst_ptc_all_null", 512'(prospective_ptc), {512{1'b1}});
    check("rst_data_zero", 512'(prospective_data), 512'(0));
    check_model();

    // First enqueue, literal.
    drive(1, D1, mk_ptc(16'h0010), 0, 0);
    tick();
    check("e1_slot0_data", 512'(prospective_data[63:0]), 512'(64'h1122334455667788));
    check("e1_slot0_ptc", 512'(prospective_ptc[127:0]),
          512'(128'h0017_0016_0015_0014_0013_0012_0011_0010));
    check("e1_count", 512'(count), 512'(1));
    check("e1_deq_valid", 512'(deq_valid), 512'(1));
    check("e1_slots123_null", 512'(prospective_ptc[511:128]), 512'({384{1'b1}}));

    // Fill, then offer a fifth while full.
    drive(1, D2, mk_ptc(16'h0020), 0, 0); tick();
    drive(1, D3, mk_ptc(16'h0030), 0, 0); tick();
    drive(1, D4, mk_ptc(16'h0040), 0, 0); tick();
    drive(1, D5, mk_ptc(16'h0050), 0, 0);
    check("full_enq_ready", 512'(enq_ready), 512'(0));
    tick();
    check("full_count_held", 512'(count), 512'(4));
    drive(1, D5, mk_ptc(16'h0050), 1, 0);
    tick();
    check("full_deq_count", 512'(count), 512'(3));
    check("full_deq_slot0", 512'(prospective_data[63:0]), 512'(D2));
    drive(1, D5, mk_ptc(16'h0050), 0, 0);
    tick();
    check("refill_count", 512'(count), 512'(4));
    check("refill_slot3", 512'(prospective_data[255:192]), 512'(D5));

    // Flush at count=3 with an enqueue offered.
    drive(0, '0, '0, 1, 0); tick();
    check("pre_flush_count", 512'(count), 512'(3));
    drive(1, DA, mk_ptc(16'h0060), 0, 1);
    tick();
    check("flush_count", 512'(count), 512'(0));
    check("flush_ptc_null", 512'(prospective_ptc), {512{1'b1}});

    // Tag kill: resident byte2 tag 0x42, new entry byte5 tag 0x42.
    pa = mk_ptc(16'h0060);
    pa[47:32] = 16'h0042;
    pb = mk_ptc(16'h0070);
    pb[95:80] = 16'h0042;
    drive(1, DA, pa, 0, 0); tick();
    drive(1, DB, pb, 0, 0); tick();
    check("kill_slot0_b2_tag", 512'(prospective_ptc[47:32]), 512'(16'hFFFF));
    check("kill_slot0_data", 512'(prospective_data[63:0]), 512'(DA));
    check("kill_slot1_b5_tag", 512'(prospective_ptc[128+80 +: 16]), 512'(16'h0042));
    check("kill_deq_ptc_b2", 512'(deq_ptc[47:32]), 512'(16'hFFFF));

    // Simultaneous dequeue and enqueue at count=2.
    drive(1, DC, mk_ptc(16'h0080), 1, 0);
    tick();
    check("sim_slot0", 512'(prospective_data[63:0]), 512'(DB));
    check("sim_slot1", 512'(prospective_data[127:64]), 512'(DC));
    check("sim_count", 512'(count), 512'(2));
    drive(0, '0, '0, 0, 0);

    // Asynchronous reset pulse between clock edges.
    #2;
    clr = 1'b0;
    #1;
    check("aclr_count", 512'(count), 512'(0));
    check("aclr_deq_valid", 512'(deq_valid), 512'(0));
    check("aclr_enq_ready", 512'(enq_ready), 512'(1));
    check("aclr_ptc_null", 512'(prospective_ptc), {512{1'b1}});
    check("aclr_data_zero", 512'(prospective_data), 512'(0));
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    check_model();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, {$urandom(), $urandom()}, rand_ptc(),
            $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
